// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default word width, streamer states and
// index-width helper.
package cnn_pkg;

    localparam int N_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int idx_w(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/conv_out_streamer.sv
// Snapshots the conv result bus on each done rising edge and replays
// it one word per valid/ready handshake, with optional ReLU.
module conv_out_streamer
    import cnn_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int OUT_CHANNELS = 4,
    parameter int OUT_SIDE     = 6,
    parameter int RELU         = 1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      done_in,
    input  logic [N*OUT_CHANNELS*OUT_SIDE*OUT_SIDE-1:0] out_mem_flat,
    output logic [N-1:0]                              m_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [idx_w(OUT_CHANNELS)-1:0]            m_chan,
    output logic [idx_w(OUT_SIDE)-1:0]                m_row,
    output logic [idx_w(OUT_SIDE)-1:0]                m_col,
    output logic                                      m_last,
    output logic                                      m_frame_last,
    output logic                                      busy,
    output logic                                      frame_done,
    output logic                                      overrun
);

    localparam int TOTAL = OUT_CHANNELS * OUT_SIDE * OUT_SIDE;
    localparam int CW    = idx_w(OUT_CHANNELS);
    localparam int RW    = idx_w(OUT_SIDE);
    localparam int EW    = idx_w(TOTAL);
    localparam logic [CW-1:0] C_MAX = CW'(OUT_CHANNELS - 1);
    localparam logic [RW-1:0] S_MAX = RW'(OUT_SIDE - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state;
    logic             r_done_d;
    logic [CW-1:0]    r_chan;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    r_col;
    logic [EW-1:0]    r_idx;
    logic             r_frame_done;
    logic             r_overrun;
    logic [N*TOTAL-1:0] r_buf;

    logic             w_stream;
    logic             w_cap;
    logic             w_hs;
    logic             w_last;
    logic             w_flast;
    logic             w_fin;
    logic             w_load;
    logic [N-1:0]     w_word;
    logic [N-1:0]     w_relu;

    // Async assert, clean release of the internal reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n  = r_rst_sync[1];
    assign w_stream = (r_state == STREAM);
    assign w_cap    = done_in & ~r_done_d;
    assign w_hs     = w_stream & m_ready;
    assign w_last   = w_stream & (r_row == S_MAX) & (r_col == S_MAX);
    assign w_flast  = w_last & (r_chan == C_MAX);
    assign w_fin    = w_hs & w_flast;
    assign w_load   = w_cap & (~w_stream | w_fin);
    assign w_word   = r_buf[int'(r_idx)*N +: N];
    assign w_relu   = ((RELU != 0) && w_word[N-1]) ? '0 : w_word;

    assign m_valid      = w_stream;
    assign busy         = w_stream;
    assign m_data       = w_stream ? w_relu : '0;
    assign m_chan       = r_chan;
    assign m_row        = r_row;
    assign m_col        = r_col;
    assign m_last       = w_last;
    assign m_frame_last = w_flast;
    assign frame_done   = r_frame_done;
    assign overrun      = r_overrun;

    // Snapshot lets conv restart while this frame drains.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf <= out_mem_flat;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= IDLE;
            r_done_d     <= 1'b0;
            r_chan       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done_d     <= done_in;
            r_frame_done <= w_fin;
            unique case (r_state)
                IDLE: begin
                    if (w_cap) begin
                        r_state <= STREAM;
                        r_chan  <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_idx   <= '0;
                    end
                end
                STREAM: begin
                    if (w_cap && !w_fin) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_fin) begin
                        r_chan <= '0;
                        r_row  <= '0;
                        r_col  <= '0;
                        r_idx  <= '0;
                        if (!w_cap) begin
                            r_state <= IDLE;
                        end
                    end else if (w_hs) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_col == S_MAX) begin
                            r_col <= '0;
                            if (r_row == S_MAX) begin
                                r_row  <= '0;
                                r_chan <= r_chan + 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/conv_out_streamer.md
# conv_out_streamer

- Drains the flattened output bus of `conv` after each `done` and serialises it as one word per handshake on a valid/ready stream.
- Optionally applies a ReLU on each word.
- Sits between `conv` and the next layer (pool / dense loader).
- Snapshots the result so `conv` can be restarted while the previous frame is still draining.

## Interface
Parameters:
- `N`, 16: word width, signed fixed point (`Q` irrelevant here, passthrough)
- `OUT_CHANNELS`, 4: number of output feature maps
- `OUT_SIDE`, 6: output map side length
- `RELU`, 1: 1 = clamp negative words to 0; 0 = passthrough

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `done_in`  in  1  `conv` done; level or pulse, rising edge is the event
- `out_mem_flat`  in  N*OUT_CHANNELS*OUT_SIDE*OUT_SIDE  `conv` result bus; element e at `[e*N +: N]`, with e = c*OUT_SIDE² + row*OUT_SIDE + col
- `m_data`  out  N  current word
- `m_valid`  out  1  `m_data` valid
- `m_ready`  in  1  downstream accepts
- `m_chan`  out  clog2(OUT_CHANNELS)  channel index of `m_data`
- `m_row`, `m_col`  out  clog2(OUT_SIDE) each  position of `m_data`
- `m_last`  out  1  last word of current channel
- `m_frame_last`  out  1  last word of frame
- `busy`  out  1  frame captured and not fully drained
- `frame_done`  out  1  one-cycle pulse after final handshake
- `overrun`  out  1  sticky: a frame was dropped

## Operation
- States: IDLE, STREAM.
- `done_d` registers `done_in`. A capture event is `done_in & ~done_d`.
- IDLE + capture event:
  - copy the whole `out_mem_flat` into the internal buffer
  - zero the counters chan/row/col
  - go to STREAM
- STREAM:
  - `m_valid` = 1
  - `m_data` = buffer[chan,row,col], ReLU'd if `RELU`; width unchanged; negative means sign bit set
  - `m_data` and the indices are derived only from registers; no combinational path from `m_ready`
- Handshake is `m_valid & m_ready`. On a handshake, advance col, then row, then chan, each wrapping to 0.
  - `m_last` = (row==OUT_SIDE-1 & col==OUT_SIDE-1)
  - `m_frame_last` = `m_last` & chan==OUT_CHANNELS-1
- Handshake on `m_frame_last`: go to IDLE; `frame_done` pulses for the following cycle.
- Capture event in STREAM, other than the final-handshake cycle: ignored, buffer untouched, `overrun` set to 1.
- Capture event coincident with the final handshake: recapture; counters go to 0 and the state stays STREAM; `frame_done` still pulses; no overrun.
- `m_valid` never drops without a handshake. `m_data` and the indices are held stable while `m_valid & ~m_ready`.
- `busy` = (state==STREAM).

## Timing
- Reset (async assert, sync deassert inside the block), all outputs 0:
  - `m_valid`, `m_data`, `m_chan`, `m_row`, `m_col`, `m_last`, `m_frame_last`, `busy`, `frame_done`, `overrun`
  - also `done_d` = 0, state = IDLE
- Reset mid-stream: `m_valid` drops immediately and the frame is discarded.
- Capture latency: `done_in` high and `done_d` low sampled at edge t means `m_valid`=1 with element 0 during cycle t+1.
- Throughput: 1 word/cycle with `m_ready` held high. A frame takes OUT_CHANNELS*OUT_SIDE² cycles, 144 at defaults.
- `done_in` already high when leaving reset: `done_d`=0, so the first sampled high is a capture.

## Structure
- Shared package `cnn_pkg`:
  - `N` default
  - state enum (IDLE, STREAM)
  - index-width helper `idx_w(x)` = max(1, $clog2(x))
- No sub-module. Buffer, counters and ReLU are inline. ReLU is a single conditional, not worth its own module.

## Test plan
- Capture, `m_ready`=1, `RELU`=0, element e loaded as e-40:
  - 144 consecutive handshakes starting cycle t+1
  - words -40..103 in order
  - `m_last` at e=35,71,107,143; `m_frame_last` only at 143
  - `frame_done` one pulse, `busy` low after
- Same data, `RELU`=1:
  - e=0..40 give 0, e=41 gives 1, e=143 gives 103
  - `m_chan`/`m_row`/`m_col` at e=50 are 1/2/2
- Backpressure: `m_ready` toggled 1,0,0,1 repeatedly. `m_data`/indices stable across stalls; no word lost or duplicated; sequence identical to case 1.
- Second `done_in` rising edge at word 20:
  - `overrun`=1 and stays set
  - rest of frame still the original data
  - capture coincident with final handshake: new frame restarts at element 0 next cycle, `overrun` unchanged
- `reset_n` pulled low for 1 ns at word 70: outputs 0 immediately. After release, no output until a new `done_in` rising edge, then a full frame of 144 words.
